// File: rtl/mem_bus_responder_pkg.sv
// mem_bus_responder_pkg
//   Shared definitions for the memory bus responder and its CPU-side peer:
//   FSM state encodings, the default error word and the wait-state limit.
package mem_bus_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;
  localparam int          WAIT_STATES_MAX  = 15;
  localparam int          CNT_W            = 4;

endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array
//   DEPTH x BITS_DATA word storage for the bus responder.
//   Ports:
//     clk    in   clock, write on posedge
//     we     in   write enable
//     waddr  in   write word address
//     wdata  in   write data
//     raddr  in   read word address (asynchronous read)
//     rdata  out  read data
//   Contents are never cleared; the caller guarantees addresses are < DEPTH.
module mem_resp_array #(
  parameter int BITS_DATA = 32,
  parameter int DEPTH     = 1024,
  parameter int AW        = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [BITS_DATA-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [BITS_DATA-1:0] rdata
);

  logic [BITS_DATA-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Target end of the CPU memory bus. One request is latched per req pulse
//   in S_IDLE, serviced against the internal word array after WAIT_STATES
//   extra cycles, and completed with a one-cycle ready pulse.
//
//   state    | meaning
//   S_IDLE   | waiting for req; request fields latched on req
//   S_WAIT   | burning wait states, counter runs down to 0
//   S_ACCESS | array read/write, MBR_R/err/ready loaded
//   S_RESP   | ready high for this one cycle
//
//   Ports:
//     clk    in   clock
//     reset  in   synchronous active-high reset
//     req    in   request strobe, sampled only in S_IDLE
//     write  in   1 = write, 0 = read (sampled with req)
//     MAR    in   word address (sampled with req)
//     MBR_W  in   write data (sampled with req)
//     MBR_R  out  read data / write echo / ERR_WORD, held until next access
//     ready  out  one-cycle completion pulse
//     busy   out  high whenever not in S_IDLE
//     err    out  out-of-range flag, valid with ready, held until next access
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int                   BITS_DATA   = 32,
  parameter int                   BITS_ADDR   = 16,
  parameter int                   DEPTH       = 1024,
  parameter int                   WAIT_STATES = 1,
  parameter logic [BITS_DATA-1:0] ERR_WORD    = BITS_DATA'(ERR_WORD_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 write,
  input  logic [BITS_ADDR-1:0] MAR,
  input  logic [BITS_DATA-1:0] MBR_W,
  output logic [BITS_DATA-1:0] MBR_R,
  output logic                 ready,
  output logic                 busy,
  output logic                 err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [BITS_ADDR:0] DEPTH_W  = (BITS_ADDR + 1)'(DEPTH);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait
    $error("mem_bus_responder: WAIT_STATES must be in 0..15");
  end
  if (DEPTH < 1 || AW > BITS_ADDR) begin : g_bad_depth
    $error("mem_bus_responder: DEPTH must be 1..2**BITS_ADDR");
  end

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BITS_ADDR-1:0] r_addr;
  logic                 r_we;
  logic [BITS_DATA-1:0] r_wd;
  logic [BITS_DATA-1:0] r_mbr, w_mbr_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_err, w_err_nxt;
  logic                 w_capture;
  logic                 w_mem_we;
  logic                 w_arr_we;
  logic                 w_in_range;
  logic [BITS_DATA-1:0] w_rdata;

  // Compare one bit wider than the address so DEPTH == 2**BITS_ADDR works.
  assign w_in_range = ({1'b0, r_addr} < DEPTH_W);

  // A reset on the S_ACCESS edge must not let the write land.
  assign w_arr_we = w_mem_we & ~reset;

  mem_resp_array #(
    .BITS_DATA (BITS_DATA),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .waddr (r_addr[AW-1:0]),
    .wdata (r_wd),
    .raddr (r_addr[AW-1:0]),
    .rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_ready_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_mbr_nxt   = r_mbr;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_ACCESS: begin
        if (!w_in_range) begin
          w_err_nxt = 1'b1;
          w_mbr_nxt = ERR_WORD;
        end else begin
          w_err_nxt = 1'b0;
          if (r_we) begin
            w_mem_we  = 1'b1;
            w_mbr_nxt = r_wd;
          end else begin
            w_mbr_nxt = w_rdata;
          end
        end
        w_ready_nxt = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_mbr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      r_mbr   <= w_mbr_nxt;
    end
  end

  // Request latches only matter while busy, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_addr <= MAR;
      r_we   <= write;
      r_wd   <= MBR_W;
    end
  end

  assign MBR_R = r_mbr;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule
